bus_datapath_seq: RTL and testbench
===================================

BUS_DATAPATH_SEQ -- requirements
Module: bus_datapath_seq

Interface
REQ-001 Parameter WIDTH, default 32: data/bus width in bits, legal range >= 4.
REQ-002 Parameter NREGS, default 16: number of general registers, a power of two, >= 2; AW = log2(NREGS).
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 clr  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to execute one operation.
REQ-006 op  input  3  operation code, encoded per REQ-016.
REQ-007 ra, rb, rc  input  AW each  destination, first-source and second-source register indices.
REQ-008 wr_en, wr_addr, wr_data  input  1/AW/WIDTH  external register load port.
REQ-009 rd_addr  input  AW; rd_data  output  WIDTH  combinational read of R[rd_addr].
REQ-010 busy  output  1  high while the sequencer is not IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle illegal-op pulse.
REQ-013 hi, lo  output  WIDTH each  contents of the HI and LO registers.

Function
REQ-014 Storage: R[0..NREGS-1], Y, Z_HI, Z_LO, HI, LO, each WIDTH bits; a single internal bus, driven by exactly one source per state, feeds every register load.
REQ-015 FSM states: IDLE, LDY, ALU, MUL, WB, WBHI, WBLO.
REQ-016 Op codes: 000 AND, 001 OR, 010 ADD, 011 SUB (Y-bus), 100 NEG (-bus), 101 NOT (~bus), 110 MUL (unsigned Y*bus), 111 illegal.
REQ-017 IDLE: on start=1 with a legal op, latch op/ra/rb/rc and move to LDY; start is ignored in every other state.
REQ-018 start=1 with op=111 in IDLE: err=1 for the next cycle only, no state change, busy stays 0.
REQ-019 LDY: bus=R[rb]; Y<=bus; next state ALU.
REQ-020 ALU, non-MUL ops: bus=R[rc]; Z_LO<=f(Y,bus) mod 2^WIDTH; Z_HI<=0; next state WB. NEG and NOT ignore Y.
REQ-021 ALU, MUL: bus=R[rc]; load the multiplicand/multiplier; clear Z_HI/Z_LO; iteration counter<=WIDTH; next state MUL.
REQ-022 MUL: one shift-add step per cycle, counter decremented; after WIDTH steps {Z_HI,Z_LO} holds the full 2*WIDTH-bit unsigned product; next state WBHI.
REQ-023 WB: bus=Z_LO; R[ra]<=bus; next state IDLE.
REQ-024 WBHI: bus=Z_HI; HI<=bus; next state WBLO. WBLO: bus=Z_LO; LO<=bus; next state IDLE.
REQ-025 done is registered: high exactly the one cycle following the WB or WBLO edge; a new start is accepted in that cycle.
REQ-026 Latency, with start sampled at edge E0: non-MUL ops write R[ra] at E3, done high in the cycle after E3; MUL writes LO at E(4+WIDTH).
REQ-027 Operands are read before writeback, so ra equal to rb and/or rc is legal and uses the old values.
REQ-028 The external write is honoured only in IDLE; wr_en in any other state is ignored.
REQ-029 An external write in the same IDLE cycle as an accepted start lands at E0; LDY/ALU then see the new value.
REQ-030 ADD/SUB/NEG wrap modulo 2^WIDTH; no carry or overflow output exists.

Reset
REQ-031 clr=0 at a rising edge: every R, Y, Z_HI, Z_LO, HI, LO and counter <= 0; state <= IDLE; busy, done and err = 0; overrides all other inputs.
REQ-032 Reset mid-operation aborts it: no register writeback and no done pulse.

Verification (WIDTH=32, NREGS=16)
REQ-033 Release clr after 2 cycles -> busy=done=err=0, hi=lo=0, rd_data=0 for every rd_addr.
REQ-034 Load R2=0x000000F0, R3=0x000000FF; start AND ra=1 rb=2 rc=3 -> R1=0x000000F0 at E3, done one cycle, busy high for exactly 3 cycles.
REQ-035 Load R4=0xFFFFFFFF, R5=2; ADD ra=6 rb=4 rc=5 -> R6=0x00000001; SUB ra=7 rb=5 rc=4 -> R7=0x00000003.
REQ-036 Load R7=0x80000000, R8=4; MUL rb=7 rc=8 -> hi=0x00000002, lo=0x00000000 at E36; done once; start pulses during busy are ignored.
REQ-037 start with op=111 -> err for one cycle, busy stays 0, no register changes.
REQ-038 clr=0 during the MUL state -> next cycle state IDLE, hi=lo=0, done never asserted.

Source files
------------

// File: rtl/bus_datapath_seq.sv
// Single-bus register datapath sequencer: AND/OR/ADD/SUB/NEG/NOT into R[ra], unsigned MUL into HI/LO.
// Latency: non-MUL writes R[ra] 3 edges after start, MUL writes LO WIDTH+4 edges after start; done one cycle later.
// Backpressure: none; start and the external write port are ignored while busy, and the caller must wait for done.
module bus_datapath_seq #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rc,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_LDY, S_ALU, S_MUL, S_WB, S_WBHI, S_WBLO
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z_hi;
  logic [WIDTH-1:0] z_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] mq;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [AW-1:0]    ra_q;
  logic [AW-1:0]    rb_q;
  logic [AW-1:0]    rc_q;
  logic             done_q;
  logic             err_q;

  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;

  // Exactly one source drives the shared bus in each state.
  always_comb begin
    bus = '0;
    case (state)
      S_LDY:         bus = regs[rb_q];
      S_ALU:         bus = regs[rc_q];
      S_WB, S_WBLO:  bus = z_lo;
      S_WBHI:        bus = z_hi;
      default:       bus = '0;
    endcase
  end

  // Single-cycle ALU between Y and the bus; results wrap modulo 2^WIDTH.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_AND:  alu_res = y & bus;
      OP_OR:   alu_res = y | bus;
      OP_ADD:  alu_res = y + bus;
      OP_SUB:  alu_res = y - bus;
      OP_NEG:  alu_res = -bus;
      OP_NOT:  alu_res = ~bus;
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: add multiplicand into the upper half when the current multiplier bit is set,
  // then shift the whole {Z_HI,Z_LO} pair right by one so the product fills in from the top.
  always_comb begin
    mul_sum = {1'b0, z_hi} + {1'b0, (mq[0] ? y : {WIDTH{1'b0}})};
  end

  // Sequencer, register file and all datapath registers.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state  <= S_IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      y      <= '0;
      z_hi   <= '0;
      z_lo   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      mq     <= '0;
      cnt    <= '0;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_en) regs[wr_addr] <= wr_data;
          if (start) begin
            if (op == OP_ILL) begin
              err_q <= 1'b1;
            end else begin
              op_q  <= op;
              ra_q  <= ra;
              rb_q  <= rb;
              rc_q  <= rc;
              state <= S_LDY;
            end
          end
        end
        S_LDY: begin
          y     <= bus;
          state <= S_ALU;
        end
        S_ALU: begin
          if (op_q == OP_MUL) begin
            mq    <= bus;
            z_hi  <= '0;
            z_lo  <= '0;
            cnt   <= CW'(WIDTH);
            state <= S_MUL;
          end else begin
            z_lo  <= alu_res;
            z_hi  <= '0;
            state <= S_WB;
          end
        end
        S_MUL: begin
          z_hi <= mul_sum[WIDTH:1];
          z_lo <= {mul_sum[0], z_lo[WIDTH-1:1]};
          mq   <= mq >> 1;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_WBHI;
        end
        S_WB: begin
          regs[ra_q] <= bus;
          done_q     <= 1'b1;
          state      <= S_IDLE;
        end
        S_WBHI: begin
          hi_q  <= bus;
          state <= S_WBLO;
        end
        S_WBLO: begin
          lo_q   <= bus;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_data = regs[rd_addr];
  assign busy    = (state != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Bench for bus_datapath_seq: scoreboard of expected writebacks, popped on each done pulse.
// Latency: checks completion edge, busy length and pre-writeback values for each op.
// Backpressure: exercises ignored start/write while busy and reset mid-multiply.
module tb_bus_datapath_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [3:0]  ra = '0, rb = '0, rc = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  logic [31:0] mdl [16];
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  typedef struct {
    bit          is_mul;
    int          ra;
    logic [31:0] val;
    logic [31:0] hi_v;
    string       tag;
  } exp_t;

  exp_t sb[$];

  bus_datapath_seq #(.WIDTH(32), .NREGS(16)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op),
    .ra(ra), .rb(rb), .rc(rc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), {32'b0, rd_data}, {32'b0, mdl[i]});
    end
  endtask

  task automatic write_reg(input int a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    mdl[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Drive one operation, push its expected result, then wait for done and compare.
  task automatic run_op(input logic [2:0] o, input int a, input int b, input int c,
                        input bit noise, input bit wsame, input int wa,
                        input logic [31:0] wd, input string tag);
    exp_t        e;
    logic [31:0] x, yv, old;
    logic [63:0] p;
    int          busy_n, lat, extra_done;
    bit          seen;
    @(negedge clk);
    start = 1'b1; op = o; ra = 4'(a); rb = 4'(b); rc = 4'(c);
    if (wsame) begin
      wr_en = 1'b1; wr_addr = 4'(wa); wr_data = wd;
      mdl[wa] = wd;
    end
    x = mdl[b];
    yv = mdl[c];
    e.is_mul = (o == 3'b110);
    e.ra = a;
    e.tag = tag;
    e.hi_v = '0;
    e.val = '0;
    case (o)
      3'b000: e.val = x & yv;
      3'b001: e.val = x | yv;
      3'b010: e.val = x + yv;
      3'b011: e.val = x - yv;
      3'b100: e.val = 32'd0 - yv;
      3'b101: e.val = ~yv;
      default: begin
        p = {32'b0, x} * {32'b0, yv};
        e.hi_v = p[63:32];
        e.val = p[31:0];
      end
    endcase
    sb.push_back(e);
    old = mdl[a];
    rd_addr = 4'(a);
    busy_n = 0; lat = 0; seen = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; wr_en = 1'b0; end
      if (noise) begin
        if (k >= 2 && k <= 10) begin
          start = 1'b1; op = 3'b010; ra = 4'd0; rb = 4'd0; rc = 4'd0;
          wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEAD_BEEF;
        end else begin
          start = 1'b0; wr_en = 1'b0;
        end
      end
      if (!e.is_mul && k == 3) chk({tag, "_pre_wb"}, {32'b0, rd_data}, {32'b0, old});
      if (busy) busy_n++;
      if (done) begin seen = 1'b1; lat = k; end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      void'(sb.pop_front());
    end else begin
      chk({tag, "_latency"}, 64'(lat), e.is_mul ? 64'd37 : 64'd4);
      chk({tag, "_busy_cycles"}, 64'(busy_n), e.is_mul ? 64'd36 : 64'd3);
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        if (e.is_mul) begin
          chk({e.tag, "_hi"}, {32'b0, hi}, {32'b0, e.hi_v});
          chk({e.tag, "_lo"}, {32'b0, lo}, {32'b0, e.val});
          mhi = e.hi_v;
          mlo = e.val;
        end else begin
          chk({e.tag, "_result"}, {32'b0, rd_data}, {32'b0, e.val});
          mdl[e.ra] = e.val;
        end
      end
      extra_done = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done) extra_done++;
      end
      chk({tag, "_done_once"}, 64'(extra_done), 64'd0);
    end
  endtask

  initial begin
    int cyc;
    int done_n;
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_err",  {63'b0, err},  64'd0);
    chk("rst_hi",   {32'b0, hi},   64'd0);
    chk("rst_lo",   {32'b0, lo},   64'd0);
    check_regs("rst");

    // Basic logic and arithmetic.
    write_reg(2, 32'h0000_00F0);
    write_reg(3, 32'h0000_00FF);
    run_op(3'b000, 1, 2, 3, 1'b0, 1'b0, 0, '0, "and");
    write_reg(4, 32'hFFFF_FFFF);
    write_reg(5, 32'd2);
    run_op(3'b010, 6, 4, 5, 1'b0, 1'b0, 0, '0, "add_wrap");
    run_op(3'b011, 7, 5, 4, 1'b0, 1'b0, 0, '0, "sub_wrap");
    run_op(3'b001, 11, 2, 5, 1'b0, 1'b0, 0, '0, "or");
    run_op(3'b101, 12, 0, 3, 1'b0, 1'b0, 0, '0, "not");
    // Destination aliases both sources: old operands must be used.
    run_op(3'b010, 2, 2, 2, 1'b0, 1'b0, 0, '0, "add_alias");
    // External write landing in the same cycle as the accepted start.
    run_op(3'b100, 10, 9, 9, 1'b0, 1'b1, 9, 32'd5, "neg_samewr");

    // Multiply, with start and write pulses during busy that must be ignored.
    write_reg(7, 32'h8000_0000);
    write_reg(8, 32'd4);
    run_op(3'b110, 0, 7, 8, 1'b1, 1'b0, 0, '0, "mul");
    write_reg(13, $urandom());
    write_reg(14, $urandom());
    run_op(3'b110, 0, 13, 14, 1'b0, 1'b0, 0, '0, "mul_rand");
    check_regs("post_mul");

    // Illegal opcode.
    @(negedge clk);
    start = 1'b1; op = 3'b111; ra = 4'd1; rb = 4'd2; rc = 4'd3;
    @(negedge clk);
    start = 1'b0;
    chk("ill_err",  {63'b0, err},  64'd1);
    chk("ill_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    chk("ill_err_clear", {63'b0, err},  64'd0);
    chk("ill_busy2",     {63'b0, busy}, 64'd0);
    chk("ill_hi", {32'b0, hi}, {32'b0, mhi});
    chk("ill_lo", {32'b0, lo}, {32'b0, mlo});
    check_regs("ill");

    // Reset in the middle of a multiply.
    write_reg(1, 32'd3);
    write_reg(2, 32'd5);
    @(negedge clk);
    start = 1'b1; op = 3'b110; ra = 4'd0; rb = 4'd1; rc = 4'd2;
    cyc = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) cyc++;
    end
    chk("mrst_running", 64'(cyc), 64'd10);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    mhi = '0;
    mlo = '0;
    chk("mrst_busy", {63'b0, busy}, 64'd0);
    chk("mrst_done", {63'b0, done}, 64'd0);
    chk("mrst_hi",   {32'b0, hi},   64'd0);
    chk("mrst_lo",   {32'b0, lo},   64'd0);
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("mrst_no_done", 64'(done_n), 64'd0);
    check_regs("mrst");
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
